// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit trace buffer and its sinks.
// Holds record kinds, the default depth and the record layout.
package commit_trace_buffer_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  localparam int DEFAULT_DEPTH = 8;

  localparam int REC_PC_W   = 32;
  localparam int REC_DATA_W = 32;

  typedef struct packed {
    logic                  kind;
    logic [REC_PC_W-1:0]   pc;
    logic [REC_DATA_W-1:0] addr;
    logic [REC_DATA_W-1:0] data;
    logic [3:0]            be;
  } trace_rec_t;

  function automatic int rec_width(
    input int pc_w,
    input int data_w
  );
    return 1 + pc_w + 2 * data_w + 4;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_trace_ram.sv
// Trace record storage: two write ports, one async read port.
// Ports: clk; we0/wa0/wd0, we1/wa1/wd1 writes; ra -> rd read.
module commit_trace_buffer_trace_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 101,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [DEPTH];

  // Contents need no reset: nothing is read
  // until count says the slot was written.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem[wa0] <= wd0;
    end
    if (we1) begin
      mem[wa1] <= wd1;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures GRF writebacks and DM stores in program order and
// drains them one per cycle over valid/ready; flags stall/overflow.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int DROP_R0 = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       grf_we,
  input  logic [PC_W-1:0]            grf_pc,
  input  logic [4:0]                 grf_addr,
  input  logic [DATA_W-1:0]          grf_wdata,
  input  logic                       dm_we,
  input  logic [PC_W-1:0]            dm_pc,
  input  logic [DATA_W-1:0]          dm_addr,
  input  logic [DATA_W-1:0]          dm_wdata,
  input  logic [3:0]                 dm_be,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic                       trc_kind,
  output logic [PC_W-1:0]            trc_pc,
  output logic [DATA_W-1:0]          trc_addr,
  output logic [DATA_W-1:0]          trc_data,
  output logic [3:0]                 trc_be,
  output logic                       stall_req,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = rec_width(PC_W, DATA_W);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] dm_wa;
  logic [CW-1:0] free;
  logic [1:0]    pushes;
  logic          grf_ok;
  logic          dm_ok;
  logic          store_g;
  logic          store_d;
  logic          drop;
  logic          pop;
  logic [RW-1:0] grf_rec;
  logic [RW-1:0] dm_rec;
  logic [RW-1:0] head_rec;

  assign grf_rec = {
    KIND_GRF,
    grf_pc,
    {{(DATA_W-5){1'b0}}, grf_addr},
    grf_wdata,
    4'b1111
  };

  assign dm_rec = {
    KIND_DM,
    dm_pc,
    dm_addr,
    dm_wdata,
    dm_be
  };

  // Space is judged on the registered count only:
  // a same-cycle pop never frees room for a push.
  // GRF (older, W stage) claims space before DM.
  always_comb begin
    free    = CW'(DEPTH) - count;
    grf_ok  = grf_we
            && !((DROP_R0 != 0) && (grf_addr == 5'd0));
    dm_ok   = dm_we && (dm_be != 4'b0000);
    store_g = grf_ok && (free != '0);
    store_d = dm_ok
            && (free >= (store_g ? CW'(2) : CW'(1)));
    drop    = (grf_ok && !store_g)
            || (dm_ok && !store_d);
    pop     = trc_valid && trc_ready;
    pushes  = {1'b0, store_g} + {1'b0, store_d};
    dm_wa   = store_g ? tail + AW'(1) : tail;
  end

  commit_trace_buffer_trace_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clk (clk),
    .we0 (store_g),
    .wa0 (tail),
    .wd0 (grf_rec),
    .we1 (store_d),
    .wa1 (dm_wa),
    .wd1 (dm_rec),
    .ra  (head),
    .rd  (head_rec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(pushes);
      count <= count + CW'(pushes) - CW'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign trc_valid = (count != '0);
  assign stall_req = (free < CW'(2));

  // Empty buffer presents an all-zero record.
  assign {trc_kind, trc_pc, trc_addr, trc_data, trc_be} =
    trc_valid ? head_rec : '0;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: queue model plus directed checks.
// Compares every cycle against the model; literals pin key points.
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        trc_valid;
  logic        trc_ready;
  logic        trc_kind;
  logic [31:0] trc_pc;
  logic [31:0] trc_addr;
  logic [31:0] trc_data;
  logic [3:0]  trc_be;
  logic        stall_req;
  logic [3:0]  count;
  logic        overflow;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  trace_rec_t mq[$];
  bit         movf;

  commit_trace_buffer #(
    .DEPTH   (DEPTH),
    .PC_W    (32),
    .DATA_W  (32),
    .DROP_R0 (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .grf_we    (grf_we),
    .grf_pc    (grf_pc),
    .grf_addr  (grf_addr),
    .grf_wdata (grf_wdata),
    .dm_we     (dm_we),
    .dm_pc     (dm_pc),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .trc_valid (trc_valid),
    .trc_ready (trc_ready),
    .trc_kind  (trc_kind),
    .trc_pc    (trc_pc),
    .trc_addr  (trc_addr),
    .trc_data  (trc_data),
    .trc_be    (trc_be),
    .stall_req (stall_req),
    .count     (count),
    .overflow  (overflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void model_step();
    int         room;
    bit         popd;
    trace_rec_t r;
    room = DEPTH - mq.size();
    popd = (mq.size() != 0) && trc_ready;
    if (grf_we && grf_addr != 5'd0) begin
      if (room > 0) begin
        r.kind = KIND_GRF;
        r.pc   = grf_pc;
        r.addr = {27'b0, grf_addr};
        r.data = grf_wdata;
        r.be   = 4'hf;
        mq.push_back(r);
        room--;
      end else begin
        movf = 1;
      end
    end
    if (dm_we && dm_be != 4'h0) begin
      if (room > 0) begin
        r.kind = KIND_DM;
        r.pc   = dm_pc;
        r.addr = dm_addr;
        r.data = dm_wdata;
        r.be   = dm_be;
        mq.push_back(r);
      end else begin
        movf = 1;
      end
    end
    if (popd) void'(mq.pop_front());
  endfunction

  function automatic void model_reset();
    mq.delete();
    movf = 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (reset && chk_en) begin
      trace_rec_t e;
      e = '0;
      if (mq.size() != 0) e = mq[0];
      chk("valid", trc_valid, mq.size() != 0);
      chk("kind", trc_kind, e.kind);
      chk("pc", trc_pc, e.pc);
      chk("addr", trc_addr, e.addr);
      chk("data", trc_data, e.data);
      chk("be", trc_be, e.be);
      chk("count", count, mq.size());
      chk("stall", stall_req, (DEPTH - mq.size()) < 2);
      chk("overflow", overflow, movf);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    grf_we = 0; grf_pc = 0; grf_addr = 0; grf_wdata = 0;
    dm_we = 0; dm_pc = 0; dm_addr = 0; dm_wdata = 0;
    dm_be = 0;
  endtask

  task automatic grf(
    input logic [31:0] pc,
    input logic [4:0]  a,
    input logic [31:0] d
  );
    grf_we = 1; grf_pc = pc; grf_addr = a; grf_wdata = d;
  endtask

  task automatic dm(
    input logic [31:0] pc,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    dm_we = 1; dm_pc = pc; dm_addr = a; dm_wdata = d;
    dm_be = be;
  endtask

  task automatic pulse_reset();
    reset = 0;
    #2;
    reset = 1;
  endtask

  initial begin
    reset = 0;
    trc_ready = 0;
    idle();
    step();
    step();
    chk("rst_valid", trc_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1;
    chk_en = 1;

    // single GRF event
    trc_ready = 1;
    grf(32'h3000, 5'd8, 32'h1234);
    step(); idle();
    chk("t1_valid", trc_valid, 1);
    chk("t1_kind", trc_kind, 0);
    chk("t1_pc", trc_pc, 32'h3000);
    chk("t1_addr", trc_addr, 8);
    chk("t1_data", trc_data, 32'h1234);
    chk("t1_be", trc_be, 4'hf);
    step();
    chk("t1_empty", trc_valid, 0);
    chk("t1_count", count, 0);

    // simultaneous GRF + DM
    grf(32'h3004, 5'd9, 32'haaaa);
    dm(32'h3008, 32'h10, 32'h5555, 4'b0011);
    step(); idle();
    chk("t2_count2", count, 2);
    chk("t2_pc0", trc_pc, 32'h3004);
    step();
    chk("t2_count1", count, 1);
    chk("t2_kind1", trc_kind, 1);
    chk("t2_addr1", trc_addr, 32'h10);
    chk("t2_be1", trc_be, 4'b0011);
    step();
    chk("t2_count0", count, 0);

    // filtered events
    grf(32'h300c, 5'd0, 32'h77);
    dm(32'h3010, 32'h20, 32'h1, 4'b0000);
    step(); idle();
    chk("t3_count", count, 0);
    chk("t3_ovf", overflow, 0);

    // fill to 7, then GRF+DM at count 7
    trc_ready = 0;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0)
        grf(32'h3100 + 4 * i, 5'(i + 1), 32'h100 + i);
      else
        dm(32'h3100 + 4 * i, 32'h40 + 4 * i,
           32'h200 + i, 4'hf);
      step(); idle();
      if (i == 5) chk("t4_stall6", stall_req, 0);
      if (i == 6) chk("t4_stall7", stall_req, 1);
    end
    grf(32'h3200, 5'd20, 32'hbeef);
    dm(32'h3204, 32'h80, 32'hdead, 4'hf);
    step(); idle();
    chk("t4_count8", count, 8);
    chk("t4_ovf", overflow, 1);
    chk("t4_head", trc_pc, 32'h3100);
    trc_ready = 1;
    repeat (7) step();
    chk("t4_last_pc", trc_pc, 32'h3200);
    chk("t4_last_kind", trc_kind, 0);
    step();
    chk("t4_drained", count, 0);

    // full buffer: pop and push together
    pulse_reset();
    trc_ready = 0;
    for (int i = 0; i < 8; i++) begin
      grf(32'h3300 + 4 * i, 5'(i + 1), 32'(i));
      step(); idle();
    end
    chk("t5_full", count, 8);
    chk("t5_ovf0", overflow, 0);
    trc_ready = 1;
    grf(32'h3400, 5'd3, 32'h3);
    step(); idle();
    chk("t5_count7", count, 7);
    chk("t5_ovf1", overflow, 1);
    chk("t5_head", trc_pc, 32'h3304);
    repeat (7) step();

    // reset mid-drain
    pulse_reset();
    trc_ready = 0;
    for (int i = 0; i < 4; i++) begin
      dm(32'h3450 + 4 * i, 32'h100 + 4 * i,
         32'(i), 4'b0001 << i);
      step(); idle();
    end
    chk("t6_count4", count, 4);
    trc_ready = 1;
    step();
    #2;
    reset = 0;
    #1;
    chk("t6_async_valid", trc_valid, 0);
    chk("t6_async_count", count, 0);
    chk("t6_async_pc", trc_pc, 0);
    reset = 1;
    step();
    grf(32'h3500, 5'd5, 32'h55);
    step(); idle();
    chk("t6_count1", count, 1);
    chk("t6_pc", trc_pc, 32'h3500);
    step();

    // mixed traffic with a toggling sink
    for (int i = 0; i < 40; i++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        grf(32'h4000 + 8 * i, 5'($urandom_range(0, 31)),
            $urandom);
      if ($urandom_range(0, 2) != 0)
        dm(32'h4004 + 8 * i, 32'h200 + 4 * i, $urandom,
           4'($urandom_range(0, 15)));
      trc_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    idle();
    trc_ready = 1;
    repeat (10) step();
    chk("final_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
